// File: rtl/kernel_kcore_h2v_hls_deadlock_confirm_unit.sv
// Per-process deadlock detection node for the HLS dataflow deadlock monitor ring.
// Confirms a self-dependency over several consecutive cycles before reporting it.
module kernel_kcore_h2v_hls_deadlock_confirm_unit #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [PROC_NUM-1:0]             dl_proc_mask,
    output logic [CNT_W-1:0]                dl_report_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        REPORT,
        HOLD
    } state_t;

    localparam logic [PROC_NUM-1:0] SELF_MASK    = {{(PROC_NUM-1){1'b0}}, 1'b1} << PROC_ID;
    localparam logic [CNT_W-1:0]    CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0]    RPT_MAX      = '1;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [PROC_NUM-1:0] dep_reg;
    logic [PROC_NUM-1:0] agg;
    logic [PROC_NUM-1:0] dep;
    logic                any_blocked;
    logic                gate_open;
    logic                cand;
    logic                token_pass;
    logic                enter_report;
    logic                detect_next;
    logic [PROC_NUM-1:0] mask_next;
    logic [CNT_W-1:0]    rpt_next;

    always_comb begin
        agg = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            if (in_chan_dep_vld_vec[i]) begin
                agg = agg | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
            end
        end
    end

    // Once a deadlock is flagged globally, incoming masks only count when a token arrives.
    assign any_blocked = |proc_dep_vld_vec;
    assign gate_open   = ~dl_detect_in | (|token_in_vec);
    assign dep         = gate_open ? agg : dep_reg;
    assign cand        = gate_open & dep[PROC_ID] & any_blocked;
    assign token_pass  = ((|token_in_vec) & ~token_clear) | origin;

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | SELF_MASK;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        detect_next  = dl_detect_out;
        mask_next    = dl_proc_mask;
        rpt_next     = dl_report_cnt;
        enter_report = 1'b0;

        case (state)
            IDLE: begin
                if (cand) begin
                    if (CONFIRM_CYCLES == 1) begin
                        enter_report = 1'b1;
                    end else begin
                        cnt_next   = CNT_W'(1);
                        state_next = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (!cand || token_clear) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CONFIRM_LAST) begin
                    enter_report = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            REPORT: begin
                if (token_clear) begin
                    detect_next = 1'b0;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (!any_blocked) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (enter_report) begin
            state_next  = REPORT;
            detect_next = 1'b1;
            mask_next   = dep | SELF_MASK;
            cnt_next    = '0;
            if (dl_report_cnt != RPT_MAX) begin
                rpt_next = dl_report_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            dl_detect_out <= 1'b0;
            dl_proc_mask  <= '0;
            dl_report_cnt <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            dl_detect_out <= detect_next;
            dl_proc_mask  <= mask_next;
            dl_report_cnt <= rpt_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_reg       <= '0;
            token_out_vec <= '0;
        end else begin
            dep_reg       <= any_blocked ? dep : '0;
            token_out_vec <= token_pass ? proc_dep_vld_vec : '0;
        end
    end

endmodule
